// File: rtl/exhaustive_stim_capture_if.sv
// rtl/exhaustive_stim_capture_if.sv - record stream bundle between the capture engine and its log/compare sink
interface exhaustive_stim_capture_if #(
    parameter int DATA_W = 7
);
    logic              rec_valid;
    logic              rec_ready;
    logic [DATA_W-1:0] rec_data;
    logic              rec_last;

    modport master (
        output rec_valid,
        output rec_data,
        output rec_last,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_data,
        input  rec_last,
        output rec_ready
    );
endinterface

// File: rtl/exhaustive_stim_capture.sv
// rtl/exhaustive_stim_capture.sv - exhaustive stimulus sweep with per-pattern response capture; optional MISR under STIM_MISR_EN
module exhaustive_stim_capture #(
    parameter int N_IN   = 6,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter int ORDER  = 0
`ifdef STIM_MISR_EN
    ,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021)
`endif
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [N_IN-1:0]      stim_o,
    input  logic [N_OUT-1:0]     dut_out_i,
`ifdef STIM_MISR_EN
    output logic [SIG_W-1:0]     signature_o,
`endif
    exhaustive_stim_capture_if.master rec
);

    localparam int REC_W = N_IN + N_OUT;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [N_IN-1:0]    idx_q;
    logic [N_IN-1:0]    stim_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               valid_q;
    logic [REC_W-1:0]   data_q;
    logic               last_q;
    logic [N_IN-1:0]    idx_d;
`ifdef STIM_MISR_EN
    logic [SIG_W-1:0]   sig_q;
`endif

    // Index-to-pattern mapping: plain binary count or reflected Gray code
    function automatic logic [N_IN-1:0] map_idx(input logic [N_IN-1:0] i);
        return (ORDER != 0) ? (i ^ (i >> 1)) : i;
    endfunction

    assign idx_d = idx_q + N_IN'(1);

    // Sweep sequencer: reset beats abort beats start; all outputs come straight from registers
    always_ff @(posedge CK) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef STIM_MISR_EN
            sig_q   <= '0;
`endif
        end else if (abort_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        idx_q   <= '0;
                        stim_q  <= map_idx('0);
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef STIM_MISR_EN
                        sig_q   <= '0;
`endif
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Sample only once the DUT has had SETTLE cycles to respond to stim
                    if (cnt_q == '0) begin
                        data_q  <= {stim_q, dut_out_i};
                        valid_q <= 1'b1;
                        last_q  <= &idx_q;
                        state_q <= S_EMIT;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    // Everything holds while the sink back-pressures
                    if (rec.rec_ready) begin
                        valid_q <= 1'b0;
`ifdef STIM_MISR_EN
                        sig_q   <= (sig_q << 1) ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(data_q);
`endif
                        if (last_q) begin
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_d;
                            stim_q  <= map_idx(idx_d);
                            cnt_q   <= CNT_INIT;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign stim_o        = stim_q;
    assign rec.rec_valid = valid_q;
    assign rec.rec_data  = data_q;
    assign rec.rec_last  = last_q;
`ifdef STIM_MISR_EN
    assign signature_o   = sig_q;
`endif

endmodule
